// File: rtl/ebpc_bit_unpacker.sv
// Bit-level stream unpacker feeding the EBPC symbol decoder: MSB-aligned look-ahead window over packed words.
// Optional EBPC_UNPACKER_STATS_EN adds bits_consumed_o / words_loaded_o counters.
module ebpc_bit_unpacker #(
    parameter int DATA_W     = 8,
    parameter int LOG_DATA_W = $clog2(DATA_W)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  vld_i,
    output logic                  rdy_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [LOG_DATA_W:0]   fill_state_o,
    output logic                  vld_o,
    input  logic [LOG_DATA_W:0]   len_i,
    input  logic                  rdy_i,
`ifdef EBPC_UNPACKER_STATS_EN
    output logic [31:0]           bits_consumed_o,
    output logic [31:0]           words_loaded_o,
`endif
    input  logic                  clr_i
);

    localparam logic [LOG_DATA_W+1:0] DW = (LOG_DATA_W+2)'(DATA_W);

    logic [2*DATA_W-1:0]   buf_q, buf_d;
    logic [LOG_DATA_W+1:0] fill_q, fill_d, fill_cons, len_ext, ret_len;
    logic                  cons, load;

    assign data_o       = buf_q[2*DATA_W-1:DATA_W];
    assign fill_state_o = (fill_q >= DW) ? DW[LOG_DATA_W:0] : fill_q[LOG_DATA_W:0];
    assign vld_o        = (fill_q != '0);
    assign rdy_o        = (fill_q <= DW);

    assign cons = vld_o && rdy_i;
    assign load = vld_i && rdy_o;

    // Retire count is clamped to the valid bits so an over-long len_i can never wrap fill_q.
    assign len_ext   = {1'b0, len_i};
    assign ret_len   = cons ? ((len_ext > fill_q) ? fill_q : len_ext) : '0;
    assign fill_cons = fill_q - ret_len;

    always_comb begin
        buf_d  = buf_q << ret_len;
        fill_d = fill_cons;
        if (load) begin
            // Zero bits below the valid region make a plain OR sufficient for appending.
            buf_d  = buf_d | ({data_i, {DATA_W{1'b0}}} >> fill_cons);
            fill_d = fill_cons + DW;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

`ifdef EBPC_UNPACKER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            bits_consumed_o <= '0;
            words_loaded_o  <= '0;
        end else begin
            bits_consumed_o <= bits_consumed_o + 32'(ret_len);
            if (load) words_loaded_o <= words_loaded_o + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_len_le_fill: assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
        (vld_o && rdy_i) |-> (len_ext <= fill_q));
`endif

endmodule

// File: tb/tb_ebpc_bit_unpacker.sv
// Self-checking bench for ebpc_bit_unpacker: directed scenarios plus randomized traffic against a bit-queue model.
module tb_ebpc_bit_unpacker;
    localparam int DATA_W = 8;
    localparam int LW     = 3;

    logic              clk_i = 1'b0;
    logic              rst_i, vld_i, rdy_o, vld_o, rdy_i, clr_i;
    logic [DATA_W-1:0] data_i, data_o;
    logic [LW:0]       fill_state_o, len_i;
`ifdef EBPC_UNPACKER_STATS_EN
    logic [31:0]       bits_consumed_o, words_loaded_o;
`endif

    ebpc_bit_unpacker #(.DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .vld_i(vld_i), .rdy_o(rdy_o),
        .data_o(data_o), .fill_state_o(fill_state_o), .vld_o(vld_o), .len_i(len_i),
        .rdy_i(rdy_i),
`ifdef EBPC_UNPACKER_STATS_EN
        .bits_consumed_o(bits_consumed_o), .words_loaded_o(words_loaded_o),
`endif
        .clr_i(clr_i)
    );

    always #5 clk_i = ~clk_i;

    bit          mq[$];
    int unsigned m_bits, m_words;
    bit          last_load;
    int          n_vec, n_err;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the stream is a queue of bits; consume pops from the front, load pushes MSB first.
    task automatic model_edge();
        int n;
        bit pre_full;
        last_load = 1'b0;
        if (rst_i || clr_i) begin
            mq.delete(); m_bits = 0; m_words = 0;
            return;
        end
        pre_full = (mq.size() > DATA_W);
        if (mq.size() != 0 && rdy_i) begin
            n = (int'(len_i) > mq.size()) ? mq.size() : int'(len_i);
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            m_bits += n;
        end
        if (vld_i && !pre_full) begin
            for (int i = DATA_W-1; i >= 0; i--) mq.push_back(data_i[i]);
            m_words++;
            last_load = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W; i++) if (i < mq.size()) w[DATA_W-1-i] = mq[i];
        chk("data_o", data_o, w);
        chk("fill_state_o", fill_state_o, (mq.size() > DATA_W) ? DATA_W : mq.size());
        chk("vld_o", vld_o, mq.size() != 0);
        chk("rdy_o", rdy_o, mq.size() <= DATA_W);
`ifdef EBPC_UNPACKER_STATS_EN
        chk("bits_consumed_o", bits_consumed_o, m_bits);
        chk("words_loaded_o", words_loaded_o, m_words);
`endif
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_model();
    endtask

    task automatic idle();
        vld_i = 0; rdy_i = 0; clr_i = 0; len_i = '0; data_i = '0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        idle(); vld_i = 1; data_i = d; tick(); idle();
    endtask

    task automatic pop(input int n);
        idle(); rdy_i = 1; len_i = (LW+1)'(n); tick(); idle();
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_bits = 0; m_words = 0;
        idle(); rst_i = 1;
        tick(); tick();
        chk("rst data_o", data_o, 0);
        chk("rst fill", fill_state_o, 0);
        chk("rst vld_o", vld_o, 0);
        chk("rst rdy_o", rdy_o, 1);
        rst_i = 0;

        push(8'hA5);
        chk("single data", data_o, 8'hA5);
        chk("single fill", fill_state_o, 8);
        push(8'h3C);
        chk("full rdy_o", rdy_o, 0);
        pop(3);
        chk("unaligned data", data_o, 8'h29);
        chk("unaligned fill", fill_state_o, 8);
        pop(5);
        chk("unaligned data2", data_o, 8'h3C);

        // fill=4 with window 1111_0000, then consume 2 while loading 0x81
        idle(); clr_i = 1; tick(); idle();
        push(8'h0F);
        pop(4);
        chk("f4 data", data_o, 8'hF0);
        chk("f4 fill", fill_state_o, 4);
        idle(); vld_i = 1; data_i = 8'h81; rdy_i = 1; len_i = 2; tick(); idle();
        chk("simul data", data_o, 8'hE0);
        chk("simul fill", fill_state_o, 8);
        chk("simul rdy_o", rdy_o, 0);

        // backpressure at fill=16
        idle(); clr_i = 1; tick(); idle();
        push(8'hAA); push(8'hCC);
        vld_i = 1; data_i = 8'h55; tick();
        chk("bp rdy_o", rdy_o, 0);
        chk("bp data", data_o, 8'hAA);
        rdy_i = 1; len_i = 8; tick();
        rdy_i = 0; len_i = 0;
        chk("bp drain data", data_o, 8'hCC);
        chk("bp drain rdy_o", rdy_o, 1);
        tick(); idle();
        chk("bp accepted rdy_o", rdy_o, 0);
        pop(8);
        chk("bp held word", data_o, 8'h55);

        // clear at fill=12 with a concurrent load
        push(8'h12); pop(4);
        idle(); clr_i = 1; vld_i = 1; data_i = 8'h77; tick(); idle();
        chk("clr fill", fill_state_o, 0);
        chk("clr vld_o", vld_o, 0);
        chk("clr data", data_o, 0);
`ifdef EBPC_UNPACKER_STATS_EN
        chk("clr bits", bits_consumed_o, 0);
        chk("clr words", words_loaded_o, 0);
`endif

        // randomized traffic; a word offered but not accepted is held unchanged
        last_load = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int mx;
            if (!vld_i || last_load) begin
                vld_i  = ($urandom % 3) != 0;
                data_i = DATA_W'($urandom);
            end
            mx    = (mq.size() > DATA_W) ? DATA_W : mq.size();
            rdy_i = ($urandom % 4) != 0;
            len_i = (LW+1)'($urandom_range(0, mx));
            clr_i = ($urandom % 64) == 0;
            rst_i = ($urandom % 400) == 0;
            tick();
        end
        rst_i = 0; idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/ebpc_bit_unpacker.md
Name: ebpc_bit_unpacker

Overview:
- Bit-level stream unpacker placed directly upstream of the EBPC symbol decoder.
- Accepts packed DATA_W-bit words from the compressed-stream input FIFO.
- Presents an MSB-aligned DATA_W-bit look-ahead window, plus the count of valid bits in it.
- Per handshake, retires a variable number of bits (0..DATA_W) chosen by the downstream decoder. This lets variable-length symbols and raw base words be read without word alignment.

Parameters:
- DATA_W, 8: packed input word width and window width; power of two, >= 4.
- LOG_DATA_W, $clog2(DATA_W): derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- data_i  in  DATA_W  packed input word; bit DATA_W-1 is first in stream order
- vld_i  in  1  input word valid
- rdy_o  out  1  input word accepted when vld_i && rdy_o
- data_o  out  DATA_W  look-ahead window; data_o[DATA_W-1] is the oldest unconsumed bit
- fill_state_o  out  LOG_DATA_W+1  valid bits in window, min(fill, DATA_W)
- vld_o  out  1  window holds >= 1 valid bit
- len_i  in  LOG_DATA_W+1  bits to retire on this handshake, 0..DATA_W
- rdy_i  in  1  consumer retires len_i bits when vld_o && rdy_i
- clr_i  in  1  soft clear, takes effect next cycle

Behaviour:
- Storage:
  - 2*DATA_W-bit shift buffer buf_q, MSB = oldest bit.
  - fill_q counter of width LOG_DATA_W+2, range 0..2*DATA_W.
  - Bits of buf_q below the fill_q valid bits are always zero.
- Reset (rst_i=1 at posedge): buf_q=0, fill_q=0. Outputs follow from that: data_o=0, fill_state_o=0, vld_o=0, rdy_o=1.
- Combinational outputs:
  - data_o = buf_q[2*DATA_W-1:DATA_W].
  - fill_state_o = fill_q>=DATA_W ? DATA_W : fill_q.
  - vld_o = (fill_q!=0).
  - rdy_o = (fill_q<=DATA_W). Depends on registered state only; there is no comb path from len_i or rdy_i to rdy_o.
- Consume (cons = vld_o && rdy_i):
  - Shift buf_q left by len_i and zero-fill.
  - fill_q decrements by len_i.
  - len_i==0 with cons is a legal no-op.
- Load (load = vld_i && rdy_o):
  - data_i is OR-ed into the buffer so its MSB lands at bit 2*DATA_W-1-fill_after_consume.
  - fill_after_consume = fill_q - (cons ? len_i : 0).
  - fill_q increments by DATA_W.
- Simultaneous consume and load in one cycle: consume is applied first, then load appends behind the remaining bits. Final fill = fill_q - len_i + DATA_W, which is always <= 2*DATA_W.
- Latency:
  - A word accepted at cycle N is visible on data_o at cycle N+1.
  - Throughput: one word per cycle while the consumer retires >= DATA_W bits per cycle.
- Illegal consume: len_i > fill_q with cons. A simulation-only assertion fires. RTL clamps the retire count to fill_q, so the result is fill_q=0, buffer all zero, and the counter never wraps.
- Full: at fill_q > DATA_W, rdy_o=0. A held vld_i/data_i must stay stable until accepted.
- Empty: at fill_q=0, vld_o=0 and rdy_i is ignored.
- clr_i: buf_q and fill_q are zeroed at the next edge. Any load or consume in the same cycle is discarded. rst_i has priority over clr_i.
- No state machine beyond the fill counter. Operating modes are decoded from fill_q:
  - EMPTY (0)
  - PARTIAL (1..DATA_W)
  - FULL (>DATA_W)

Optional Feature:
- Macro: EBPC_UNPACKER_STATS_EN.
- Defined:
  - Adds output bits_consumed_o, 32 bits, reset/clr to 0.
  - Increments by the effective retired count on each consume; wraps modulo 2^32.
  - Adds output words_loaded_o, 32 bits, incremented per load.
- Undefined: neither port exists; no counter logic is synthesised.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> data_o=0, fill_state_o=0, vld_o=0, rdy_o=1.
- Single word: load 8'hA5 (DATA_W=8), rdy_i=0 -> next cycle data_o=8'hA5, fill_state_o=8.
- Unaligned consume across words:
  - Load 8'hA5 then 8'h3C; consume len_i=3 -> data_o=8'h29, internal fill=13, fill_state_o=8.
  - Consume len_i=5 -> data_o=8'h3C.
- Simultaneous load and consume:
  - Start from fill=4 (window 4'hF followed by zeros).
  - Consume len_i=2 while loading 8'h81 -> data_o=8'hE0 (2'b11 followed by 1000_00), fill=10, rdy_o=0.
- Backpressure: fill=16, vld_i held high with 8'h55 -> rdy_o=0. After consume len_i=8, the word is accepted next cycle and fill returns to 16.
- clr_i with fill=12 and a concurrent load -> next cycle fill_state_o=0, vld_o=0, data_o=0. With EBPC_UNPACKER_STATS_EN, both counters read 0.
